// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths for the memory-port arbiter slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  // Address/data width of the cache request and response paths.
  localparam int MPA_DATA_WIDTH = 32;

  // Transaction-ID width; 2**MPA_ID_WIDTH transactions may be in flight.
  localparam int MPA_ID_WIDTH = 4;

endpackage : mem_port_arbiter_pkg

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Round-robin pick: first requester at or after ptr, wrapping modulo N.
// Latency: combinational.
// Backpressure: none; the caller gates req when no grant may be issued.
// Ports: req (per-requester valid), ptr (search start), grant (one-hot or zero).
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic [N-1:0]                      req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic [N-1:0]                      grant
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/mem_port_arbiter.sv
// Arbitrates NUM_CH requesters onto one cache port, tags requests with IDs, routes responses back.
// Latency: grant to cache_valid_out 1 cycle; cache response to resp_valid 1 cycle.
// Backpressure: cache_stall_in holds the output register; no grant while it is held or all IDs are in use.
// Ports: req_* / req_ready (requesters), flush (per-channel squash), cache_*_out / cache_stall_in
//        (request to cache), cache_*_in / cache_ready_in (response), resp_* (to owner), busy, id_error.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_WIDTH = MPA_DATA_WIDTH,
  parameter int ID_WIDTH   = MPA_ID_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_CH-1:0]            req_rw,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH-1:0]            flush,
  output logic [DATA_WIDTH-1:0]        cache_addr_out,
  output logic [DATA_WIDTH-1:0]        cache_data_out,
  output logic                         cache_rw_out,
  output logic [ID_WIDTH-1:0]          cache_id_out,
  output logic                         cache_valid_out,
  input  logic                         cache_stall_in,
  input  logic [DATA_WIDTH-1:0]        cache_data_in,
  input  logic [ID_WIDTH-1:0]          cache_id_in,
  input  logic                         cache_ready_in,
  output logic [NUM_CH-1:0]            resp_valid,
  output logic [DATA_WIDTH-1:0]        resp_data,
  output logic                         busy,
  output logic                         id_error
);

  localparam int NUM_ID  = 2 ** ID_WIDTH;
  localparam int OWNER_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // ID table: one entry per transaction ID.
  logic [NUM_ID-1:0]  ent_alloc;
  logic [NUM_ID-1:0]  ent_squash;
  logic [OWNER_W-1:0] ent_owner [NUM_ID];

  logic [OWNER_W-1:0]    rr_ptr;
  logic [NUM_CH-1:0]     grant;
  logic                  out_free;
  logic                  id_avail;
  logic                  grant_en;
  logic                  any_grant;
  logic [OWNER_W-1:0]    grant_ch;
  logic [ID_WIDTH-1:0]   free_id;
  logic [DATA_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_rw;
  logic                  rsp_hit;
  logic [OWNER_W-1:0]    rsp_owner;
  logic                  rsp_deliver;

  assign out_free  = !cache_valid_out || !cache_stall_in;
  // Availability is judged on the table as it stood before this cycle's free,
  // so an ID released this cycle is only reusable from the next one.
  assign id_avail  = ~&ent_alloc;
  assign grant_en  = out_free && id_avail;
  assign any_grant = |grant;
  assign req_ready = grant;
  assign busy      = (|ent_alloc) || cache_valid_out;

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .req   (req_valid & {NUM_CH{grant_en}}),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Lowest unallocated ID, granted channel index and its request fields.
  always_comb begin
    free_id  = '0;
    grant_ch = '0;
    sel_addr = '0;
    sel_data = '0;
    sel_rw   = 1'b0;
    for (int i = NUM_ID - 1; i >= 0; i--) begin
      if (!ent_alloc[i]) free_id = ID_WIDTH'(i);
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (grant[c]) begin
        grant_ch = OWNER_W'(c);
        sel_addr = req_addr[c*DATA_WIDTH +: DATA_WIDTH];
        sel_data = req_data[c*DATA_WIDTH +: DATA_WIDTH];
        sel_rw   = req_rw[c];
      end
    end
  end

  // A response is forwarded only if its entry is live, not squashed, and its
  // owner is not being flushed in this same cycle.
  assign rsp_hit     = cache_ready_in && ent_alloc[cache_id_in];
  assign rsp_owner   = ent_owner[cache_id_in];
  assign rsp_deliver = rsp_hit && !ent_squash[cache_id_in] && !flush[rsp_owner];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent_alloc  <= '0;
      ent_squash <= '0;
    end else begin
      for (int i = 0; i < NUM_ID; i++) begin
        if (ent_alloc[i] && flush[ent_owner[i]]) ent_squash[i] <= 1'b1;
      end
      if (rsp_hit) ent_alloc[cache_id_in] <= 1'b0;
      // free_id is never the entry being freed, so these writes cannot collide.
      if (any_grant) begin
        ent_alloc[free_id]  <= 1'b1;
        ent_squash[free_id] <= flush[grant_ch];
      end
    end
  end

  // Owner is only meaningful while allocated, so it needs no reset.
  always_ff @(posedge clk) begin
    if (any_grant) ent_owner[free_id] <= grant_ch;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= (int'(grant_ch) == NUM_CH - 1) ? '0 : grant_ch + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cache_valid_out <= 1'b0;
      cache_addr_out  <= '0;
      cache_data_out  <= '0;
      cache_rw_out    <= 1'b0;
      cache_id_out    <= '0;
    end else if (any_grant) begin
      cache_valid_out <= 1'b1;
      cache_addr_out  <= sel_addr;
      cache_data_out  <= sel_data;
      cache_rw_out    <= sel_rw;
      cache_id_out    <= free_id;
    end else if (out_free) begin
      cache_valid_out <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= '0;
      resp_data  <= '0;
      id_error   <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (rsp_deliver) begin
        resp_valid[rsp_owner] <= 1'b1;
        resp_data             <= cache_data_in;
      end
      if (cache_ready_in && !ent_alloc[cache_id_in]) id_error <= 1'b1;
    end
  end

endmodule : mem_port_arbiter

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int NID = 16;

  logic              clk;
  logic              reset;
  logic [NCH-1:0]    req_valid;
  logic [NCH*DW-1:0] req_addr;
  logic [NCH*DW-1:0] req_data;
  logic [NCH-1:0]    req_rw;
  logic [NCH-1:0]    req_ready;
  logic [NCH-1:0]    flush;
  logic [DW-1:0]     cache_addr_out;
  logic [DW-1:0]     cache_data_out;
  logic              cache_rw_out;
  logic [IW-1:0]     cache_id_out;
  logic              cache_valid_out;
  logic              cache_stall_in;
  logic [DW-1:0]     cache_data_in;
  logic [IW-1:0]     cache_id_in;
  logic              cache_ready_in;
  logic [NCH-1:0]    resp_valid;
  logic [DW-1:0]     resp_data;
  logic              busy;
  logic              id_error;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: ID table, pointer, output register, response regs.
  bit          m_alloc [NID];
  int          m_owner [NID];
  bit          m_sq    [NID];
  int          m_ptr;
  bit          m_cv;
  logic [31:0] m_addr, m_data, m_rd;
  bit          m_rw;
  int          m_id;
  int          m_rv;
  bit          m_err;

  mem_port_arbiter #(.NUM_CH(NCH), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_rw(req_rw),
    .req_ready(req_ready), .flush(flush),
    .cache_addr_out(cache_addr_out), .cache_data_out(cache_data_out),
    .cache_rw_out(cache_rw_out), .cache_id_out(cache_id_out),
    .cache_valid_out(cache_valid_out), .cache_stall_in(cache_stall_in),
    .cache_data_in(cache_data_in), .cache_id_in(cache_id_in), .cache_ready_in(cache_ready_in),
    .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy), .id_error(id_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic mreset();
    for (int i = 0; i < NID; i++) begin
      m_alloc[i] = 0; m_owner[i] = 0; m_sq[i] = 0;
    end
    m_ptr = 0; m_cv = 0; m_addr = '0; m_data = '0; m_rd = '0;
    m_rw = 0; m_id = 0; m_rv = 0; m_err = 0;
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_rw = '0; flush = '0; cache_stall_in = 1'b0;
    cache_ready_in = 1'b0; cache_id_in = '0; cache_data_in = '0;
  endtask

  // Called shortly after a rising edge with the inputs for this cycle set.
  task automatic tick();
    int  g, nid, rid, exp_ready;
    bit  ofree, afree, hit;
    #1;
    ofree = !m_cv || !cache_stall_in;
    afree = 0;
    nid   = -1;
    for (int i = 0; i < NID; i++) if (!m_alloc[i]) begin
      afree = 1;
      if (nid < 0) nid = i;
    end
    g = -1;
    if (ofree && afree)
      for (int k = 0; k < NCH; k++) begin
        int c;
        c = (m_ptr + k) % NCH;
        if (g < 0 && req_valid[c]) g = c;
      end
    exp_ready = (g < 0) ? 0 : (1 << g);
    check("req_ready", 64'(req_ready), 64'(exp_ready));

    m_rv = 0;
    rid  = int'(cache_id_in);
    hit  = cache_ready_in && m_alloc[rid];
    if (cache_ready_in && !m_alloc[rid]) m_err = 1;
    if (hit && !m_sq[rid] && !flush[m_owner[rid]]) begin
      m_rv = 1 << m_owner[rid];
      m_rd = cache_data_in;
    end
    for (int i = 0; i < NID; i++) if (m_alloc[i] && flush[m_owner[i]]) m_sq[i] = 1;
    if (hit) m_alloc[rid] = 0;
    if (g >= 0) begin
      m_alloc[nid] = 1; m_owner[nid] = g; m_sq[nid] = flush[g];
      m_cv = 1; m_addr = req_addr[g*DW +: DW]; m_data = req_data[g*DW +: DW];
      m_rw = req_rw[g]; m_id = nid; m_ptr = (g + 1) % NCH;
    end else if (ofree) begin
      m_cv = 0;
    end

    @(posedge clk);
    #1;
    check("cache_valid_out", 64'(cache_valid_out), 64'(m_cv));
    check("cache_addr_out", 64'(cache_addr_out), 64'(m_addr));
    check("cache_data_out", 64'(cache_data_out), 64'(m_data));
    check("cache_rw_out", 64'(cache_rw_out), 64'(m_rw));
    check("cache_id_out", 64'(cache_id_out), 64'(m_id));
    check("resp_valid", 64'(resp_valid), 64'(m_rv));
    check("resp_data", 64'(resp_data), 64'(m_rd));
    begin
      bit anyal;
      anyal = 0;
      for (int i = 0; i < NID; i++) if (m_alloc[i]) anyal = 1;
      check("busy", 64'(busy), 64'(anyal || m_cv));
    end
    check("id_error", 64'(id_error), 64'(m_err));
  endtask

  // Asynchronous reset pulse, checked before any clock edge can act.
  task automatic do_reset();
    idle_inputs();
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_id_error", 64'(id_error), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_cache_valid", 64'(cache_valid_out), 64'd0);
    check("async_rst_resp_valid", 64'(resp_valid), 64'd0);
    mreset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic respond(int id, logic [31:0] d);
    cache_ready_in = 1'b1; cache_id_in = IW'(id); cache_data_in = d;
  endtask

  initial begin
    reset = 1'b0;
    req_addr = '0; req_data = '0;
    idle_inputs();
    mreset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_cache_valid", 64'(cache_valid_out), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_id_error", 64'(id_error), 64'd0);
    check("reset_resp_valid", 64'(resp_valid), 64'd0);
    reset = 1'b1;

    // Single read on ch0, then its response.
    req_valid = 2'b01; req_rw = 2'b00; req_addr[31:0] = 32'h100;
    tick();
    check("single_id", 64'(cache_id_out), 64'd0);
    req_valid = '0;
    respond(0, 32'hDEAD);
    tick();
    cache_ready_in = 1'b0;
    tick();
    check("single_resp_data", 64'(resp_data), 64'hDEAD);

    // Fairness from a fresh pointer: both channels request continuously.
    do_reset();
    req_valid = 2'b11; req_rw = 2'b10;
    for (int k = 0; k < 4; k++) begin
      req_addr = {32'h2000 + 32'(k), 32'h1000 + 32'(k)};
      req_data = {$urandom, $urandom};
      tick();
    end
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      respond(k, $urandom);
      tick();
    end
    cache_ready_in = 1'b0;
    tick();

    // Stall hold: issue, stall for 3 cycles with a competing request, release.
    req_valid = 2'b01; req_addr = {32'hB0B0, 32'hA0A0}; req_data = {$urandom, $urandom};
    tick();
    cache_stall_in = 1'b1; req_valid = 2'b10;
    repeat (3) tick();
    cache_stall_in = 1'b0;
    tick();
    req_valid = '0;
    tick();
    tick();

    // ID exhaustion and reuse of a freed ID one cycle later.
    do_reset();
    req_valid = 2'b11;
    for (int k = 0; k < 16; k++) begin
      req_addr = {$urandom, $urandom};
      tick();
    end
    tick();
    check("exhaust_ready", 64'(req_ready), 64'd0);
    respond(5, 32'h5555);
    tick();
    cache_ready_in = 1'b0;
    tick();
    check("exhaust_reuse_id", 64'(cache_id_out), 64'd5);
    req_valid = '0;
    tick();

    // Flush: ch1 owns IDs 2 and 3; their responses are dropped.
    do_reset();
    req_valid = 2'b01;
    tick(); tick();
    req_valid = 2'b10;
    tick(); tick();
    req_valid = '0;
    flush = 2'b10;
    tick();
    flush = '0;
    for (int id = 2; id <= 3; id++) begin
      respond(id, 32'hF00 + 32'(id));
      tick();
    end
    for (int id = 0; id <= 1; id++) begin
      respond(id, 32'hC00 + 32'(id));
      tick();
    end
    cache_ready_in = 1'b0;
    tick();
    check("flush_busy", 64'(busy), 64'd0);

    // Randomised traffic against the model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      int live [$];
      req_valid = NCH'($urandom_range(0, 3));
      req_rw    = NCH'($urandom_range(0, 3));
      req_addr  = {$urandom, $urandom};
      req_data  = {$urandom, $urandom};
      cache_stall_in = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 15) == 0) ? NCH'($urandom_range(1, 3)) : '0;
      cache_ready_in = 1'b0;
      for (int i = 0; i < NID; i++) if (m_alloc[i]) live.push_back(i);
      if (live.size() > 0 && $urandom_range(0, 1) == 1)
        respond(live[$urandom_range(0, live.size() - 1)], $urandom);
      tick();
    end
    idle_inputs();
    tick();

    // Bogus ID, then asynchronous reset clears id_error and busy.
    do_reset();
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    respond(7, 32'h7777);
    tick();
    check("bogus_id_error", 64'(id_error), 64'd1);
    check("bogus_resp_valid", 64'(resp_valid), 64'd0);
    do_reset();

    // Reset mid-transaction discards IDs; a late response flags an error.
    req_valid = 2'b11;
    tick(); tick();
    do_reset();
    respond(0, 32'h1234);
    tick();
    cache_ready_in = 1'b0;
    tick();
    check("late_resp_id_error", 64'(id_error), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_mem_port_arbiter

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_CH, 2: number of requester channels.
- DATA_WIDTH, 32: address and data width.
- ID_WIDTH, 4: transaction-ID width; 2**ID_WIDTH outstanding transactions.
REQ-002 Ports SHALL be:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_CH  per-channel request valid.
- req_addr  in  NUM_CH*DATA_WIDTH  per-channel address.
- req_data  in  NUM_CH*DATA_WIDTH  per-channel write data.
- req_rw  in  NUM_CH  1 = write, 0 = read.
- req_ready  out  NUM_CH  request accepted this cycle.
- flush  in  NUM_CH  squash all outstanding transactions of the channel.
- cache_addr_out  out  DATA_WIDTH  request address.
- cache_data_out  out  DATA_WIDTH  request write data.
- cache_rw_out  out  1  request direction.
- cache_id_out  out  ID_WIDTH  transaction ID.
- cache_valid_out  out  1  request valid.
- cache_stall_in  in  1  cache cannot take the request this cycle.
- cache_data_in  in  DATA_WIDTH  response data.
- cache_id_in  in  ID_WIDTH  response ID.
- cache_ready_in  in  1  response valid.
- resp_valid  out  NUM_CH  one-hot response strobe.
- resp_data  out  DATA_WIDTH  response data.
- busy  out  1  any ID allocated or cache_valid_out high.
- id_error  out  1  sticky flag: response received for an unallocated ID.

Function
REQ-003 The output register SHALL be free when cache_valid_out=0, or when cache_valid_out=1 and cache_stall_in=0.
REQ-004 Grant rule:
- At most one channel is granted per cycle, only when the output register is free and at least one ID is unallocated.
- Among channels with req_valid=1, the grant goes to the first channel at or after the round-robin pointer.
- req_ready is combinational and is 1 only for the granted channel.
REQ-005 On grant, the pointer SHALL advance to the granted channel + 1, wrapping modulo NUM_CH. The pointer is unchanged when nothing is granted.
REQ-006 An accepted request SHALL appear on cache_*_out the next cycle, with cache_valid_out=1 and cache_id_out set to the lowest unallocated ID in the pre-update table.
REQ-007 While cache_stall_in=1, cache_*_out SHALL hold stable.
REQ-008 cache_valid_out SHALL drop the cycle after the request is consumed, unless a new grant occurred.
REQ-009 Each ID entry SHALL hold: allocated bit, owner channel (clog2(NUM_CH) bits, minimum 1), squashed bit. Allocation sets allocated=1 and squashed=0.
REQ-010 Response handling when cache_ready_in=1 and entry[cache_id_in] is allocated:
- The entry is freed.
- If not squashed: the next cycle, resp_valid[owner]=1 for exactly one cycle and resp_data=cache_data_in.
- If squashed: no resp_valid is produced.
REQ-011 A response with cache_ready_in=1 for an unallocated ID SHALL be ignored and SHALL set id_error, which holds until reset.
REQ-012 An ID freed in cycle N SHALL NOT be reallocated in cycle N. It SHALL be allocatable from cycle N+1.
REQ-013 flush[c] in cycle N SHALL set squashed on every allocated entry owned by c.
- A request from c accepted in cycle N is allocated already squashed.
- A squashed request still in the output register is still issued to the cache.
- A response arriving in cycle N for c is suppressed.
REQ-014 All 2**ID_WIDTH IDs allocated SHALL deassert all req_ready. A simultaneous free does not grant that cycle (REQ-012).
REQ-015 resp_data SHALL hold its last value when resp_valid=0.

Reset
REQ-016 Asserting reset (low) SHALL asynchronously clear:
- cache_valid_out, cache_addr_out, cache_data_out, cache_rw_out, cache_id_out;
- resp_valid, resp_data;
- id_error, busy;
- the round-robin pointer (to 0);
- all entry allocated and squashed bits.
REQ-017 Reset mid-transaction SHALL discard all outstanding IDs. Later responses for those IDs set id_error.

Structure
REQ-018 DATA_WIDTH and the ID-width default SHALL come from the shared globals header. Entry field widths SHALL be derived constants local to the module.
REQ-019 The round-robin arbiter SHALL be one sub-module, rr_arbiter, with parameter N, inputs req and ptr, and one-hot output grant. Everything else SHALL live in mem_port_arbiter.

Verification
REQ-020 Single read:
- Stimulus: ch0 requests addr 0x100, rw=0.
- Required: req_ready[0]=1; next cycle cache_valid_out=1, cache_id_out=0.
- Then: cache_ready_in with id 0, data 0xDEAD produces resp_valid=01, resp_data=0xDEAD one cycle later.
REQ-021 Fairness:
- Stimulus: ch0 and ch1 request continuously, no stall.
- Required: grants alternate 0,1,0,1; IDs 0,1,2,3.
REQ-022 Stall hold:
- Stimulus: cache_stall_in=1 for 3 cycles after an issue.
- Required: cache_*_out unchanged; req_ready=0; the request is consumed on the first unstalled cycle.
REQ-023 ID exhaustion:
- Stimulus: 16 requests issued with no responses.
- Required: req_ready=0.
- Then: a response for ID 5 in cycle N gives no grant in N; a grant in N+1 receives ID 5.
REQ-024 Flush:
- Stimulus: ch1 has IDs 2 and 3 outstanding; flush[1] pulses; responses for IDs 2 and 3 arrive.
- Required: no resp_valid; both IDs free; busy=0.
REQ-025 Bogus ID and reset:
- Stimulus: response for unallocated ID 7.
- Required: id_error=1, no resp_valid.
- Then: asserting reset clears id_error and busy immediately, without waiting for a clock edge.
